// File: rtl/gtp_pll_rst_seq.sv
// Power-up, reset and lock supervisor for the GTP PLL wrapper.
// Sequences PLL_PWD/PLL_RST/RESET_ODIV/GATEO from a filtered PLL_LOCK and exposes a single READY qualifier.
module gtp_pll_rst_seq #(
    parameter int             RST_CYCLES   = 16,
    parameter int             LOCK_FILTER  = 64,
    parameter int             GATE_DELAY   = 8,
    parameter int             LOCK_TIMEOUT = 65535,
    parameter logic [4:0]     GATE_MASK    = 5'b00001,
    parameter int             CNT_W        = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PWD_REQ,
    input  logic       RESTART_REQ,
    input  logic       PLL_LOCK_IN,
    output logic       PLL_PWD,
    output logic       PLL_RST,
    output logic       RESET_ODIV,
    output logic [4:0] GATEO,
    output logic       READY,
    output logic [7:0] LOSS_CNT,
    output logic       TIMEOUT_ERR,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_PWD       = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_FILTER    = 3'd3,
        ST_ODIV_REL  = 3'd4,
        ST_RUN       = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_DELAY - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta, lock_s;
    logic             timeout_hit, loss_hit;
    logic             pwd_d, rst_d, odiv_d, ready_d;
    logic [4:0]       gate_d;

    // PLL_LOCK is asynchronous to CLK; only lock_s is used past this point.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= PLL_LOCK_IN;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        loss_hit    = 1'b0;
        case (state)
            ST_PWD:       if (!PWD_REQ) state_next = ST_RESET;
            ST_RESET:     if (cnt == RST_LAST) state_next = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = ST_FILTER;
                end else if (cnt == TO_LAST) begin
                    state_next  = ST_RESET;
                    timeout_hit = 1'b1;
                end
            end
            ST_FILTER: begin
                if (!lock_s)                 state_next = ST_WAIT_LOCK;
                else if (cnt == FILTER_LAST) state_next = ST_ODIV_REL;
            end
            ST_ODIV_REL: begin
                if (!lock_s)               state_next = ST_RESET;
                else if (cnt == GATE_LAST) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_next = ST_RESET;
                    loss_hit   = 1'b1;
                end
            end
            default: state_next = ST_RESET;
        endcase
        // Restart is meaningless while already powered down or in reset.
        if (RESTART_REQ && state != ST_PWD && state != ST_RESET) state_next = ST_RESET;
        if (PWD_REQ) state_next = ST_PWD;
    end

    // Outputs decode the next state so they move on the same edge as the state register.
    always_comb begin
        pwd_d   = 1'b0;
        rst_d   = 1'b0;
        odiv_d  = 1'b0;
        gate_d  = 5'b00000;
        ready_d = 1'b0;
        case (state_next)
            ST_PWD: begin
                pwd_d  = 1'b1;
                rst_d  = 1'b1;
                odiv_d = 1'b1;
            end
            ST_RESET: begin
                rst_d  = 1'b1;
                odiv_d = 1'b1;
            end
            ST_WAIT_LOCK, ST_FILTER: odiv_d = 1'b1;
            ST_RUN: begin
                gate_d  = GATE_MASK;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_RESET;
            cnt         <= '0;
            PLL_PWD     <= 1'b0;
            PLL_RST     <= 1'b1;
            RESET_ODIV  <= 1'b1;
            GATEO       <= 5'b00000;
            READY       <= 1'b0;
            LOSS_CNT    <= 8'd0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= (state_next != state) ? '0 : cnt + 1'b1;
            PLL_PWD    <= pwd_d;
            PLL_RST    <= rst_d;
            RESET_ODIV <= odiv_d;
            GATEO      <= gate_d;
            READY      <= ready_d;
            if (loss_hit && LOSS_CNT != 8'hff) LOSS_CNT <= LOSS_CNT + 8'd1;
            if (timeout_hit) TIMEOUT_ERR <= 1'b1;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_gtp_pll_rst_seq.sv
// Directed bench for gtp_pll_rst_seq: reset sequence, lock filter, timeout retry,
// lock-loss saturation, restart and power-down with hand-computed edge numbers.
module tb_gtp_pll_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwd_req;
    logic       restart_req;
    logic       pll_lock_in;
    logic       pll_pwd;
    logic       pll_rst;
    logic       reset_odiv;
    logic [4:0] gateo;
    logic       ready;
    logic [7:0] loss_cnt;
    logic       timeout_err;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;
    int now      = 0;
    int exp_loss = 0;
    int t        = 0;

    always #5 clk = ~clk;

    gtp_pll_rst_seq #(
        .RST_CYCLES  (16),
        .LOCK_FILTER (64),
        .GATE_DELAY  (8),
        .LOCK_TIMEOUT(100),
        .GATE_MASK   (5'b00001),
        .CNT_W       (16)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .PWD_REQ    (pwd_req),
        .RESTART_REQ(restart_req),
        .PLL_LOCK_IN(pll_lock_in),
        .PLL_PWD    (pll_pwd),
        .PLL_RST    (pll_rst),
        .RESET_ODIV (reset_odiv),
        .GATEO      (gateo),
        .READY      (ready),
        .LOSS_CNT   (loss_cnt),
        .TIMEOUT_ERR(timeout_err),
        .state_dbg  (state_dbg)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, now, got, exp);
        end
    endtask

    // Advance to #1 after rising edge number target (edges counted from RST release).
    task automatic run_to(input int target);
        while (now < target) begin
            @(posedge clk);
            #1;
            now++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish at edge %0d", now);
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        pwd_req     = 1'b0;
        restart_req = 1'b0;
        pll_lock_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        now = 0;

        check_eq("rst_pll_rst", pll_rst, 1);
        check_eq("rst_pll_pwd", pll_pwd, 0);
        check_eq("rst_odiv", reset_odiv, 1);
        check_eq("rst_gateo", gateo, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_loss", loss_cnt, 0);
        check_eq("rst_timeout", timeout_err, 0);

        // Initial lock: PLL_RST falls at edge 16, READY at edge 115.
        run_to(15);  check_eq("pll_rst_hold_15", pll_rst, 1);
        run_to(16);  check_eq("pll_rst_fall_16", pll_rst, 0);
        run_to(40);  pll_lock_in = 1'b1;
        run_to(106); check_eq("odiv_hold_106", reset_odiv, 1);
        run_to(107); check_eq("odiv_rel_107", reset_odiv, 0);
        run_to(114); check_eq("ready_early_114", ready, 0);
        run_to(115); check_eq("ready_115", ready, 1);
        check_eq("gateo_run_115", gateo, 5'b00001);
        check_eq("pll_rst_run_115", pll_rst, 0);

        // Lock loss, then timeout retry every 116 cycles.
        run_to(120); pll_lock_in = 1'b0;
        run_to(122); check_eq("loss_ready_still_122", ready, 1);
        run_to(123);
        check_eq("loss_ready_123", ready, 0);
        check_eq("loss_gateo_123", gateo, 0);
        check_eq("loss_pll_rst_123", pll_rst, 1);
        check_eq("loss_cnt_1", loss_cnt, 1);
        exp_loss = 1;
        run_to(238);
        check_eq("to_pre_pll_rst", pll_rst, 0);
        check_eq("to_pre_err", timeout_err, 0);
        run_to(239);
        check_eq("to_err_239", timeout_err, 1);
        check_eq("to_pll_rst_239", pll_rst, 1);
        run_to(254); check_eq("retry_rst_hold_254", pll_rst, 1);
        run_to(255); check_eq("retry_rst_fall_255", pll_rst, 0);
        run_to(354); check_eq("retry2_pre_354", pll_rst, 0);
        run_to(355); check_eq("retry2_rst_355", pll_rst, 1);

        // Lock drop for 3 cycles at filter count 30 restarts the filter.
        run_to(380); pll_lock_in = 1'b1;
        run_to(413); pll_lock_in = 1'b0;
        run_to(416); pll_lock_in = 1'b1;
        run_to(447); check_eq("filter_not_reused_447", reset_odiv, 1);
        run_to(482); check_eq("odiv_hold_482", reset_odiv, 1);
        run_to(483); check_eq("odiv_rel_483", reset_odiv, 0);
        run_to(490); check_eq("ready_early_490", ready, 0);
        run_to(491); check_eq("ready_491", ready, 1);

        // 300 lock losses in RUN: LOSS_CNT saturates at 255.
        for (int i = 0; i < 300; i++) begin
            t = now;
            pll_lock_in = 1'b0;
            run_to(t + 2); check_eq("drop_gateo_pre", gateo, 5'b00001);
            run_to(t + 3);
            check_eq("drop_gateo_off", gateo, 0);
            check_eq("drop_pll_rst", pll_rst, 1);
            pll_lock_in = 1'b1;
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            run_to(t + 92);
            check_eq("relock_ready", ready, 1);
            check_eq("loss_cnt_sat", loss_cnt, exp_loss);
        end

        // Restart request in RUN.
        t = now;
        restart_req = 1'b1;
        run_to(t + 1);
        restart_req = 1'b0;
        check_eq("restart_ready", ready, 0);
        check_eq("restart_gateo", gateo, 0);
        check_eq("restart_pll_rst", pll_rst, 1);
        check_eq("restart_no_loss", loss_cnt, 255);
        run_to(t + 16); check_eq("restart_rst_hold", pll_rst, 1);
        run_to(t + 17); check_eq("restart_rst_fall", pll_rst, 0);
        run_to(t + 89); check_eq("restart_ready_early", ready, 0);
        run_to(t + 90); check_eq("restart_ready_back", ready, 1);

        // Power-down from RUN, then asynchronous RST mid-FILTER.
        t = now;
        pwd_req = 1'b1;
        run_to(t + 1);
        check_eq("pwd_pll_pwd", pll_pwd, 1);
        check_eq("pwd_pll_rst", pll_rst, 1);
        check_eq("pwd_ready", ready, 0);
        check_eq("pwd_gateo", gateo, 0);
        run_to(t + 5); pwd_req = 1'b0;
        run_to(t + 6);
        check_eq("pwd_rel_pll_pwd", pll_pwd, 0);
        check_eq("pwd_rel_pll_rst", pll_rst, 1);
        run_to(t + 21); check_eq("pwd_rst_hold", pll_rst, 1);
        run_to(t + 22); check_eq("pwd_rst_fall", pll_rst, 0);
        run_to(t + 50);
        check_eq("filter_odiv", reset_odiv, 1);
        check_eq("filter_pll_rst", pll_rst, 0);
        rst = 1'b1;
        #1;
        check_eq("async_pll_rst", pll_rst, 1);
        check_eq("async_loss", loss_cnt, 0);
        check_eq("async_timeout", timeout_err, 0);
        check_eq("async_ready", ready, 0);
        check_eq("async_pll_pwd", pll_pwd, 0);
        check_eq("async_odiv", reset_odiv, 1);
        check_eq("async_gateo", gateo, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
